// File: rtl/sha1_pkg.sv
// sha1_pkg: shared types and constants for the SHA1 message writer and engine.
package sha1_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_FLUSH,
    S_LAUNCH,
    S_WAIT,
    S_WDIG,
    S_FIN
  } state_e;
  localparam int SHA1_DIGEST_WORDS = 5;
  localparam int LANE_W = 8;
  localparam logic [159:0] SHA1_IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
endpackage

// File: rtl/sha1_msg_writer_if.sv
// sha1_msg_writer_if: host byte stream plus dpsram write port B.
interface sha1_msg_writer_if #(
  parameter int ADDR_W = 16
) ();
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              in_last;
  logic              port_B_clk;
  logic [ADDR_W-1:0] port_B_addr;
  logic [31:0]       port_B_data_in;
  logic              port_B_we;
  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, port_B_clk, port_B_addr, port_B_data_in, port_B_we
  );
  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, port_B_clk, port_B_addr, port_B_data_in, port_B_we
  );
endinterface

// File: rtl/sha1_byte_packer.sv
// sha1_byte_packer: packs bytes LSB-first into 32-bit words with a registered write strobe.
module sha1_byte_packer
  import sha1_pkg::*;
(
  input  logic              clk,
  input  logic              nreset,
  input  logic              clr_i,
  input  logic              valid_i,
  input  logic [LANE_W-1:0] data_i,
  input  logic              last_i,
  output logic [31:0]       word_o,
  output logic              wr_o,
  output logic [31:0]       count_o
);
  logic [31:0] count_q, count_d, acc_q, acc_d, word_q, word_d;
  logic        wr_q, wr_d;
  logic [1:0]  lane;
  always_comb begin
    lane    = count_q[1:0];
    count_d = count_q;
    acc_d   = acc_q;
    word_d  = word_q;
    wr_d    = 1'b0;
    if (clr_i) begin
      count_d = '0;
      acc_d   = '0;
    end else if (valid_i) begin
      // lane 0 starts a fresh word, so upper lanes of a short final word stay zero
      acc_d   = (lane == 2'd0 ? 32'd0 : acc_q) | (32'(data_i) << (LANE_W * lane));
      count_d = count_q + 32'(count_q != '1);
      wr_d    = (lane == 2'd3) | last_i;
      word_d  = wr_d ? acc_d : word_q;
    end
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      count_q <= '0;
      acc_q   <= '0;
      word_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      acc_q   <= acc_d;
      word_q  <= word_d;
      wr_q    <= wr_d;
    end
  end
  assign word_o  = word_q;
  assign wr_o    = wr_q;
  assign count_o = count_q;
endmodule

// File: rtl/sha1_msg_writer.sv
// sha1_msg_writer: streams a message into dpsram, runs the SHA1 engine, writes back the digest.
module sha1_msg_writer
  import sha1_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DIGEST_WORDS = SHA1_DIGEST_WORDS
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      start,
  input  logic [31:0]               cfg_msg_addr,
  input  logic [31:0]               cfg_dig_addr,
  sha1_msg_writer_if.slave          bus,
  output logic                      hash_start,
  output logic [31:0]               hash_msg_addr,
  output logic [31:0]               hash_msg_size,
  input  logic [32*DIGEST_WORDS-1:0] hash_digest,
  input  logic                      hash_done,
  output logic                      busy,
  output logic                      done
);
  localparam int DW  = 32 * DIGEST_WORDS;
  localparam int DCW = $clog2(DIGEST_WORDS + 1);
  state_e            state_q, state_d;
  logic [31:0]       msg_base_q;
  logic [ADDR_W-1:0] dig_base_q, addr_q;
  logic [DW-1:0]     dig_q;
  logic [DCW-1:0]    didx_q;
  logic              accept, pk_clr, pk_wr, take_dig, unused;
  logic [31:0]       pk_word, pk_count;
  assign accept   = bus.in_valid & bus.in_ready;
  assign pk_clr   = (state_q == S_IDLE) & start;
  assign take_dig = (state_q == S_WAIT) & hash_done;
  assign unused   = ^cfg_dig_addr;
  sha1_byte_packer u_packer (
    .clk     (clk),
    .nreset  (nreset),
    .clr_i   (pk_clr),
    .valid_i (accept),
    .data_i  (bus.in_data),
    .last_i  (bus.in_last),
    .word_o  (pk_word),
    .wr_o    (pk_wr),
    .count_o (pk_count)
  );
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = start ? S_FILL : S_IDLE;
      S_FILL:   state_d = (accept && bus.in_last) ? S_FLUSH : S_FILL;
      S_FLUSH:  state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   state_d = hash_done ? S_WDIG : S_WAIT;
      S_WDIG:   state_d = (didx_q == DCW'(DIGEST_WORDS - 1)) ? S_FIN : S_WDIG;
      default:  state_d = S_IDLE;
    endcase
  end
  // one address register walks the message words, then is reloaded for the digest
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= S_IDLE;
      msg_base_q <= '0;
      dig_base_q <= '0;
      addr_q     <= '0;
      dig_q      <= '0;
      didx_q     <= '0;
    end else begin
      state_q <= state_d;
      if (pk_clr) begin
        msg_base_q <= cfg_msg_addr;
        dig_base_q <= cfg_dig_addr[ADDR_W-1:0];
        addr_q     <= cfg_msg_addr[ADDR_W-1:0];
      end else if (take_dig) begin
        addr_q <= dig_base_q;
      end else if (pk_wr || state_q == S_WDIG) begin
        addr_q <= addr_q + ADDR_W'(4);
      end
      if (take_dig) begin
        dig_q  <= hash_digest;
        didx_q <= '0;
      end else if (state_q == S_WDIG) begin
        dig_q  <= dig_q << 32;
        didx_q <= didx_q + DCW'(1);
      end
    end
  end
  assign bus.in_ready       = state_q == S_FILL;
  assign bus.port_B_clk     = clk;
  assign bus.port_B_addr    = addr_q;
  assign bus.port_B_we      = pk_wr | (state_q == S_WDIG);
  assign bus.port_B_data_in = (state_q == S_WDIG) ? dig_q[DW-1 -: 32] : pk_word;
  assign hash_start         = state_q == S_LAUNCH;
  assign hash_msg_addr      = msg_base_q;
  assign hash_msg_size      = pk_count;
  assign busy               = state_q != S_IDLE;
  assign done               = state_q == S_FIN;
endmodule

// File: tb/tb_sha1_msg_writer.sv
// tb_sha1_msg_writer: directed self-checking bench for sha1_msg_writer.
module tb_sha1_msg_writer;
  logic         clk = 1'b0, nreset = 1'b0, start = 1'b0, hash_done = 1'b0;
  logic [31:0]  cfg_msg_addr = '0, cfg_dig_addr = '0;
  logic [159:0] hash_digest = '0, dg = '0;
  logic         hash_start, busy, done;
  logic [31:0]  hash_msg_addr, hash_msg_size;
  sha1_msg_writer_if #(.ADDR_W(16)) bus ();
  sha1_msg_writer #(.ADDR_W(16), .DIGEST_WORDS(5)) dut (
    .clk           (clk),
    .nreset        (nreset),
    .start         (start),
    .cfg_msg_addr  (cfg_msg_addr),
    .cfg_dig_addr  (cfg_dig_addr),
    .bus           (bus),
    .hash_start    (hash_start),
    .hash_msg_addr (hash_msg_addr),
    .hash_msg_size (hash_msg_size),
    .hash_digest   (hash_digest),
    .hash_done     (hash_done),
    .busy          (busy),
    .done          (done)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [15:0] wa[$];
  logic [31:0] wd[$];
  int          wc[$];
  int          hs_n = 0, done_n = 0, hs_cyc = 0, done_cyc = 0, t_last = 0, u_cyc = 0;
  logic [31:0] hs_size = '0, hs_addr = '0;
  int          n_checks = 0, n_pass = 0;
  logic [31:0] exp_dig [5] = '{32'hA9993E36, 32'h4706816A, 32'hBA3E2571, 32'h7850C26C, 32'h9CD0D89D};
  always @(negedge clk) begin
    if (bus.port_B_we) begin
      wa.push_back(bus.port_B_addr);
      wd.push_back(bus.port_B_data_in);
      wc.push_back(cyc);
    end
    if (hash_start) begin
      hs_n++;
      hs_cyc  = cyc;
      hs_size = hash_msg_size;
      hs_addr = hash_msg_addr;
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
  end
  task automatic send(input logic [63:0] b, input int n, input bit gappy);
    for (int i = 0; i < n; i++) begin
      if (gappy) repeat ($urandom_range(0, 2)) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        bus.in_last  = 1'($urandom);
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = b[8*i +: 8];
      bus.in_last  = (i == n - 1);
      t_last = cyc;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask
  task automatic job(input logic [31:0] ma, input logic [31:0] da, input logic [63:0] b,
                     input int n, input bit gappy, input int dly, input bit poke);
    wa.delete(); wd.delete(); wc.delete();
    hs_n = 0; done_n = 0;
    cfg_msg_addr = ma; cfg_dig_addr = da; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send(b, n, gappy);
    for (int k = 0; k < 20 && !hash_start; k++) begin @(posedge clk); #1; end
    for (int k = 0; k < dly; k++) begin
      if (poke && k == 3) begin
        start = 1'b1; cfg_msg_addr = 32'hDEAD0000; cfg_dig_addr = 32'hBEEF0000;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    hash_digest = dg; hash_done = 1'b1; u_cyc = cyc;
    for (int k = 0; k < 20 && !done; k++) begin @(posedge clk); #1; end
    hash_done = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", bus.in_ready); else n_pass++;
    n_checks++; if (bus.port_B_we !== 1'b0) $display("FAIL reset_we got %b want 0", bus.port_B_we); else n_pass++;
    n_checks++; if (bus.port_B_addr !== 16'h0) $display("FAIL reset_addr got %h want 0", bus.port_B_addr); else n_pass++;
    n_checks++; if (bus.port_B_data_in !== 32'h0) $display("FAIL reset_data got %h want 0", bus.port_B_data_in); else n_pass++;
    n_checks++; if (hash_start !== 1'b0) $display("FAIL reset_hash_start got %b want 0", hash_start); else n_pass++;
    n_checks++; if (hash_msg_size !== 32'h0) $display("FAIL reset_size got %h want 0", hash_msg_size); else n_pass++;
    n_checks++; if (hash_msg_addr !== 32'h0) $display("FAIL reset_msg_addr got %h want 0", hash_msg_addr); else n_pass++;
    nreset = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic test_abc();
    dg = 160'h01234567_89ABCDEF_FEDCBA98_76543210_0F1E2D3C;
    job(32'h1000, 32'h2000, 64'h636261, 3, 1'b0, 2, 1'b0);
    n_checks++; if (wa.size() !== 6) $display("FAIL abc_nwrites got %0d want 6", wa.size()); else n_pass++;
    n_checks++; if (wa[0] !== 16'h1000) $display("FAIL abc_addr got %h want 1000", wa[0]); else n_pass++;
    n_checks++; if (wd[0] !== 32'h00636261) $display("FAIL abc_data got %h want 00636261", wd[0]); else n_pass++;
    n_checks++; if (wc[0] !== t_last + 1) $display("FAIL abc_write_cycle got %0d want %0d", wc[0], t_last + 1); else n_pass++;
    n_checks++; if (hs_n !== 1) $display("FAIL abc_hash_start_count got %0d want 1", hs_n); else n_pass++;
    n_checks++; if (hs_cyc !== t_last + 2) $display("FAIL abc_launch_cycle got %0d want %0d", hs_cyc, t_last + 2); else n_pass++;
    n_checks++; if (hs_size !== 32'd3) $display("FAIL abc_size got %0d want 3", hs_size); else n_pass++;
    n_checks++; if (hs_addr !== 32'h1000) $display("FAIL abc_msg_addr got %h want 1000", hs_addr); else n_pass++;
    n_checks++; if (wd[1] !== 32'h01234567) $display("FAIL abc_dig0 got %h want 01234567", wd[1]); else n_pass++;
    n_checks++; if (done_n !== 1) $display("FAIL abc_done_count got %0d want 1", done_n); else n_pass++;
  endtask
  task automatic test_five_wrap();
    job(32'h0001FFFC, 32'h3000, 64'h05_04030201, 5, 1'b0, 2, 1'b0);
    n_checks++; if (wa.size() !== 7) $display("FAIL five_nwrites got %0d want 7", wa.size()); else n_pass++;
    n_checks++; if (wa[0] !== 16'hFFFC) $display("FAIL five_addr0 got %h want fffc", wa[0]); else n_pass++;
    n_checks++; if (wd[0] !== 32'h04030201) $display("FAIL five_data0 got %h want 04030201", wd[0]); else n_pass++;
    n_checks++; if (wa[1] !== 16'h0000) $display("FAIL five_addr1_wrap got %h want 0000", wa[1]); else n_pass++;
    n_checks++; if (wd[1] !== 32'h00000005) $display("FAIL five_data1 got %h want 00000005", wd[1]); else n_pass++;
    n_checks++; if (wc[1] !== t_last + 1) $display("FAIL five_write_cycle got %0d want %0d", wc[1], t_last + 1); else n_pass++;
    n_checks++; if (hs_size !== 32'd5) $display("FAIL five_size got %0d want 5", hs_size); else n_pass++;
    n_checks++; if (hs_addr !== 32'h0001FFFC) $display("FAIL five_msg_addr got %h want 0001fffc", hs_addr); else n_pass++;
  endtask
  task automatic test_digest();
    dg = 160'hA9993E36_4706816A_BA3E2571_7850C26C_9CD0D89D;
    job(32'h0100, 32'h3000, 64'h61, 1, 1'b0, 50, 1'b0);
    n_checks++; if (wa.size() !== 6) $display("FAIL dig_nwrites got %0d want 6", wa.size()); else n_pass++;
    n_checks++; if (wd[0] !== 32'h00000061) $display("FAIL dig_one_byte got %h want 00000061", wd[0]); else n_pass++;
    n_checks++; if (hs_size !== 32'd1) $display("FAIL dig_size got %0d want 1", hs_size); else n_pass++;
    n_checks++; if (u_cyc !== hs_cyc + 50) $display("FAIL dig_done_delay got %0d want %0d", u_cyc, hs_cyc + 50); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (wa[1+i] !== 16'(32'h3000 + 4 * i)) $display("FAIL dig_addr%0d got %h want %h", i, wa[1+i], 32'h3000 + 4 * i); else n_pass++;
      n_checks++; if (wd[1+i] !== exp_dig[i]) $display("FAIL dig_data%0d got %h want %h", i, wd[1+i], exp_dig[i]); else n_pass++;
      n_checks++; if (wc[1+i] !== u_cyc + 1 + i) $display("FAIL dig_cycle%0d got %0d want %0d", i, wc[1+i], u_cyc + 1 + i); else n_pass++;
    end
    n_checks++; if (done_cyc !== u_cyc + 6) $display("FAIL dig_done_cycle got %0d want %0d", done_cyc, u_cyc + 6); else n_pass++;
    n_checks++; if (done_n !== 1) $display("FAIL dig_done_count got %0d want 1", done_n); else n_pass++;
  endtask
  task automatic test_random_valid();
    job(32'h4000, 32'h5000, 64'h88776655_44332211, 8, 1'b1, 3, 1'b0);
    n_checks++; if (wa.size() !== 7) $display("FAIL rnd_nwrites got %0d want 7", wa.size()); else n_pass++;
    n_checks++; if (wa[0] !== 16'h4000) $display("FAIL rnd_addr0 got %h want 4000", wa[0]); else n_pass++;
    n_checks++; if (wd[0] !== 32'h44332211) $display("FAIL rnd_data0 got %h want 44332211", wd[0]); else n_pass++;
    n_checks++; if (wa[1] !== 16'h4004) $display("FAIL rnd_addr1 got %h want 4004", wa[1]); else n_pass++;
    n_checks++; if (wd[1] !== 32'h88776655) $display("FAIL rnd_data1 got %h want 88776655", wd[1]); else n_pass++;
    n_checks++; if (hs_size !== 32'd8) $display("FAIL rnd_size got %0d want 8", hs_size); else n_pass++;
  endtask
  task automatic test_abort();
    wa.delete(); wd.delete(); wc.delete();
    cfg_msg_addr = 32'h1000; cfg_dig_addr = 32'h2000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'hAA;
    @(posedge clk); #1;
    bus.in_data = 8'hBB;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    #2 nreset = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL abort_in_ready got %b want 0", bus.in_ready); else n_pass++;
    n_checks++; if (bus.port_B_addr !== 16'h0) $display("FAIL abort_addr got %h want 0", bus.port_B_addr); else n_pass++;
    n_checks++; if (bus.port_B_data_in !== 32'h0) $display("FAIL abort_data got %h want 0", bus.port_B_data_in); else n_pass++;
    n_checks++; if (hash_msg_size !== 32'h0) $display("FAIL abort_size got %h want 0", hash_msg_size); else n_pass++;
    n_checks++; if (hash_msg_addr !== 32'h0) $display("FAIL abort_msg_addr got %h want 0", hash_msg_addr); else n_pass++;
    repeat (3) @(posedge clk);
    #1 nreset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (wa.size() !== 0) $display("FAIL abort_no_write got %0d writes want 0", wa.size()); else n_pass++;
    n_checks++; if (bus.port_B_we !== 1'b0) $display("FAIL abort_we got %b want 0", bus.port_B_we); else n_pass++;
    test_abc();
  endtask
  task automatic test_start_in_wait();
    dg = 160'h11111111_22222222_33333333_44444444_55555555;
    job(32'h6000, 32'h7000, 64'h636261, 3, 1'b0, 10, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (hs_n !== 1) $display("FAIL wait_hash_start_count got %0d want 1", hs_n); else n_pass++;
    n_checks++; if (done_n !== 1) $display("FAIL wait_done_count got %0d want 1", done_n); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL wait_busy_after got %b want 0", busy); else n_pass++;
    n_checks++; if (hash_msg_addr !== 32'h6000) $display("FAIL wait_msg_addr got %h want 6000", hash_msg_addr); else n_pass++;
    n_checks++; if (wa.size() !== 6) $display("FAIL wait_nwrites got %0d want 6", wa.size()); else n_pass++;
    n_checks++; if (wa[1] !== 16'h7000) $display("FAIL wait_dig_addr got %h want 7000", wa[1]); else n_pass++;
    n_checks++; if (wd[5] !== 32'h55555555) $display("FAIL wait_dig4 got %h want 55555555", wd[5]); else n_pass++;
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    test_reset();
    test_abc();
    test_five_wrap();
    test_digest();
    test_random_valid();
    test_abort();
    test_start_in_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
